// File: rtl/ntt_const_bank.sv
// Runtime-programmable constant bank for the NTT/FFT datapath.
// Validated host writes land in a shadow set that is copied atomically to the active set while the core is idle.
module ntt_const_bank #(
    parameter int DATA_WIDTH = 50,
    parameter int BR_WIDTH   = 53,
    parameter int NUM_C      = 16,
    parameter int NUM_INV    = 5,
    parameter int ADDR_W     = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [BR_WIDTH-1:0]           wr_data,
    output logic                          wr_err,
    input  logic                          commit,
    input  logic                          fft_idle,
    output logic                          commit_done,
    output logic                          commit_err,
    output logic                          cfg_valid,
    input  logic                          inverse,
    output logic [DATA_WIDTH-1:0]         modulus,
    output logic [BR_WIDTH-1:0]           pre_computing,
    output logic [NUM_C*DATA_WIDTH-1:0]   const_out,
    output logic [NUM_INV*DATA_WIDTH-1:0] inv_out
);
    localparam int NENT   = 2 + 2*NUM_C + NUM_INV;
    localparam int A_FWD  = 2;
    localparam int A_INVC = 2 + NUM_C;
    localparam int A_INV  = 2 + 2*NUM_C;

    typedef enum logic {IDLE, PEND} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0]              sh_mod, act_mod;
    logic [BR_WIDTH-1:0]                sh_bar, act_bar;
    logic [NUM_C-1:0][DATA_WIDTH-1:0]   sh_fwd, sh_ic, act_fwd, act_ic, const_q;
    logic [NUM_INV-1:0][DATA_WIDTH-1:0] sh_inv, act_inv;
    logic [NENT-1:0]                    mask, mask_nxt;

    logic [DATA_WIDTH-1:0] lo;
    logic hi_zero, is_mod, is_bar, is_con, wr_acc, wr_ok;

    assign wr_ready = (state == IDLE);
    assign lo       = wr_data[DATA_WIDTH-1:0];
    assign hi_zero  = (wr_data >> DATA_WIDTH) == '0;
    assign is_mod   = (wr_addr == '0);
    assign is_bar   = (wr_addr == ADDR_W'(1));
    assign is_con   = (32'(wr_addr) >= 32'(A_FWD)) && (32'(wr_addr) < 32'(NENT));
    assign wr_acc   = wr_valid & wr_ready;
    // Constants are range-checked against the shadow modulus, not the active one.
    assign wr_ok    = wr_acc & (is_bar
                    | (is_mod & hi_zero & lo[0] & (lo >= DATA_WIDTH'(3)))
                    | (is_con & hi_zero & (lo < sh_mod)));

    // A new modulus invalidates every constant derived from the old one.
    always_comb begin
        mask_nxt = mask;
        if (wr_ok) begin
            if (is_mod) begin
                mask_nxt      = '0;
                mask_nxt[1:0] = {mask[1], 1'b1};
            end else begin
                mask_nxt[wr_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mod <= '0;
            sh_bar <= '0;
            sh_fwd <= '0;
            sh_ic  <= '0;
            sh_inv <= '0;
        end else if (wr_ok) begin
            if (is_mod) sh_mod <= lo;
            if (is_bar) sh_bar <= wr_data;
            for (int i = 0; i < NUM_C; i++) begin
                if (32'(wr_addr) == 32'(A_FWD + i))  sh_fwd[i] <= lo;
                if (32'(wr_addr) == 32'(A_INVC + i)) sh_ic[i]  <= lo;
            end
            for (int i = 0; i < NUM_INV; i++)
                if (32'(wr_addr) == 32'(A_INV + i)) sh_inv[i] <= lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            cfg_valid   <= 1'b0;
            act_mod     <= '0;
            act_bar     <= '0;
            act_fwd     <= '0;
            act_ic      <= '0;
            act_inv     <= '0;
            const_q     <= '0;
        end else begin
            mask        <= mask_nxt;
            wr_err      <= wr_acc & ~wr_ok;
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
            const_q     <= inverse ? act_ic : act_fwd;
            case (state)
                IDLE: if (commit) begin
                    if (&mask_nxt) state      <= PEND;
                    else           commit_err <= 1'b1;
                end
                PEND: if (fft_idle) begin
                    act_mod     <= sh_mod;
                    act_bar     <= sh_bar;
                    act_fwd     <= sh_fwd;
                    act_ic      <= sh_ic;
                    act_inv     <= sh_inv;
                    cfg_valid   <= 1'b1;
                    commit_done <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign modulus       = act_mod;
    assign pre_computing = act_bar;
    assign const_out     = const_q;
    assign inv_out       = act_inv;
endmodule

// File: tb/tb_ntt_const_bank.sv
// Self-checking bench for ntt_const_bank: directed scenarios plus randomized traffic
// checked against an address-indexed model of the shadow/active sets.
module tb_ntt_const_bank;
    localparam int DW = 50;
    localparam int BW = 53;
    localparam int NC = 16;
    localparam int NI = 5;
    localparam int AW = 6;
    localparam int NE = 2 + 2*NC + NI;

    localparam logic [BW-1:0] MOD  = 55822321;
    localparam logic [BW-1:0] BAR  = 161354796;
    localparam logic [DW-1:0] C52F = 21016252;
    localparam logic [DW-1:0] C52I = 34806069;
    localparam logic [DW-1:0] C31F = 49886006;
    localparam logic [DW-1:0] INV2 = 27911161;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_valid = 1'b0, commit = 1'b0, fft_idle = 1'b1, inverse = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] wr_data = '0;
    logic wr_ready, wr_err, commit_done, commit_err, cfg_valid;
    logic [DW-1:0] modulus;
    logic [BW-1:0] pre_computing;
    logic [NC*DW-1:0] const_out;
    logic [NI*DW-1:0] inv_out;

    ntt_const_bank #(.DATA_WIDTH(DW), .BR_WIDTH(BW), .NUM_C(NC), .NUM_INV(NI), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_err(wr_err), .commit(commit), .fft_idle(fft_idle),
        .commit_done(commit_done), .commit_err(commit_err), .cfg_valid(cfg_valid),
        .inverse(inverse), .modulus(modulus), .pre_computing(pre_computing),
        .const_out(const_out), .inv_out(inv_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int load_errs;

    // Model: entries indexed by write address, written flags, active copy, pending flag.
    logic [BW-1:0] m_sh [NE];
    logic [BW-1:0] m_act [NE];
    bit m_wr [NE];
    bit m_pend, m_cfg;
    logic [NC*DW-1:0] m_cq;
    bit exp_wr_err, exp_done, exp_cerr;

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            m_sh[i] = '0; m_act[i] = '0; m_wr[i] = 0;
        end
        m_pend = 0; m_cfg = 0; m_cq = '0;
        exp_wr_err = 0; exp_done = 0; exp_cerr = 0;
    endtask

    function automatic logic [NC*DW-1:0] act_set(bit inv);
        logic [NC*DW-1:0] r;
        for (int k = 0; k < NC; k++) r[k*DW +: DW] = m_act[2 + (inv ? NC : 0) + k][DW-1:0];
        return r;
    endfunction

    function automatic logic [NI*DW-1:0] act_inv_set();
        logic [NI*DW-1:0] r;
        for (int k = 0; k < NI; k++) r[k*DW +: DW] = m_act[2 + 2*NC + k][DW-1:0];
        return r;
    endfunction

    function automatic bit legal(int a, logic [BW-1:0] d);
        bit fits = (d < (BW'(1) << DW));
        if (a == 0) return fits && d[0] && d >= 3;
        if (a == 1) return 1;
        if (a < NE) return fits && d < m_sh[0];
        return 0;
    endfunction

    // Advances one clock with the current inputs and updates model expectations for that edge.
    task automatic tick();
        int a = int'(wr_addr);
        bit acc = wr_valid && !m_pend;
        bit ok = legal(a, wr_data);
        bit all_set = 1;
        exp_wr_err = acc && !ok;
        exp_done = 0;
        exp_cerr = 0;
        m_cq = act_set(inverse);
        if (acc && ok) begin
            if (a == 0) for (int i = 2; i < NE; i++) m_wr[i] = 0;
            m_sh[a] = wr_data;
            m_wr[a] = 1;
        end
        if (!m_pend) begin
            if (commit) begin
                for (int i = 0; i < NE; i++) if (!m_wr[i]) all_set = 0;
                if (all_set) m_pend = 1;
                else exp_cerr = 1;
            end
        end else if (fft_idle) begin
            for (int i = 0; i < NE; i++) m_act[i] = m_sh[i];
            m_cfg = 1; exp_done = 1; m_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [BW-1:0] d);
        wr_valid = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic load_set();
        load_errs = 0;
        wr(0, MOD);
        if (wr_err) load_errs++;
        wr(1, BAR);
        if (wr_err) load_errs++;
        for (int a = 2; a < NE; a++) begin
            logic [BW-1:0] d;
            d = BW'($urandom % 32'(MOD));
            if (a == 2 + 10) d = BW'(C52F);
            if (a == 2 + NC + 10) d = BW'(C52I);
            if (a == 2 + 15) d = BW'(C31F);
            if (a == 2 + 2*NC) d = BW'(INV2);
            wr(a, d);
            if (wr_err) load_errs++;
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if ({wr_err, commit_done, commit_err, cfg_valid} !== 4'b0 || modulus !== '0 ||
            pre_computing !== '0 || const_out !== '0 || inv_out !== '0) begin
            n_err++; $display("FAIL reset_outputs: got err/done/cerr/cfg=%b mod=%0d pre=%0d exp all 0",
                {wr_err, commit_done, commit_err, cfg_valid}, modulus, pre_computing);
        end
        n_chk++;
        if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_chk++;
        if (commit_err !== 1'b1 || !exp_cerr) begin
            n_err++; $display("FAIL empty_commit_err: got %b exp 1", commit_err);
        end
        n_chk++;
        if (wr_ready !== 1'b1 || cfg_valid !== 1'b0) begin
            n_err++; $display("FAIL empty_commit_state: ready=%b cfg=%b exp 1/0", wr_ready, cfg_valid);
        end
        tick();
        n_chk++;
        if (commit_err !== 1'b0) begin n_err++; $display("FAIL cerr_one_pulse: got %b exp 0", commit_err); end
    endtask

    task automatic test_full_load();
        load_set();
        n_chk++;
        if (load_errs != 0) begin n_err++; $display("FAIL load_wr_err: got %0d exp 0", load_errs); end
        fft_idle = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_chk++;
        if (commit_done !== 1'b0 || wr_ready !== 1'b0) begin
            n_err++; $display("FAIL commit_edge_n: done=%b ready=%b exp 0/0", commit_done, wr_ready);
        end
        tick();
        n_chk++;
        if (commit_done !== 1'b1 || cfg_valid !== 1'b1) begin
            n_err++; $display("FAIL commit_edge_n1: done=%b cfg=%b exp 1/1", commit_done, cfg_valid);
        end
        n_chk++;
        if (modulus !== MOD[DW-1:0] || pre_computing !== BAR) begin
            n_err++; $display("FAIL active_mod_bar: mod=%0d pre=%0d exp %0d %0d", modulus, pre_computing, MOD, BAR);
        end
        n_chk++;
        if (inv_out[0 +: DW] !== INV2) begin
            n_err++; $display("FAIL inv2: got %0d exp %0d", inv_out[0 +: DW], INV2);
        end
        tick();
        n_chk++;
        if (commit_done !== 1'b0) begin n_err++; $display("FAIL done_one_pulse: got %b exp 0", commit_done); end
        n_chk++;
        if (const_out[10*DW +: DW] !== C52F || const_out !== m_cq) begin
            n_err++; $display("FAIL fwd_c52: got %0d exp %0d", const_out[10*DW +: DW], C52F);
        end
    endtask

    task automatic test_inverse();
        inverse = 1'b1;
        #1;
        n_chk++;
        if (const_out[10*DW +: DW] !== C52F) begin
            n_err++; $display("FAIL inv_not_early: got %0d exp %0d", const_out[10*DW +: DW], C52F);
        end
        tick();
        n_chk++;
        if (const_out[10*DW +: DW] !== C52I || const_out !== m_cq) begin
            n_err++; $display("FAIL inv_c52: got %0d exp %0d", const_out[10*DW +: DW], C52I);
        end
        inverse = 1'b0;
        tick();
        n_chk++;
        if (const_out[15*DW +: DW] !== C31F || const_out !== m_cq) begin
            n_err++; $display("FAIL fwd_c31: got %0d exp %0d", const_out[15*DW +: DW], C31F);
        end
    endtask

    task automatic test_bad_writes();
        wr(2 + 14, MOD);
        n_chk++;
        if (wr_err !== 1'b1 || !exp_wr_err) begin n_err++; $display("FAIL c30_eq_mod: wr_err=%b exp 1", wr_err); end
        wr(40, BW'($urandom % 1000));
        n_chk++;
        if (wr_err !== 1'b1 || !exp_wr_err) begin n_err++; $display("FAIL illegal_addr: wr_err=%b exp 1", wr_err); end
        wr(0, MOD - 1);
        n_chk++;
        if (wr_err !== 1'b1 || !exp_wr_err) begin n_err++; $display("FAIL even_mod: wr_err=%b exp 1", wr_err); end
        tick();
        n_chk++;
        if (wr_err !== 1'b0) begin n_err++; $display("FAIL wr_err_pulse: got %b exp 0", wr_err); end
    endtask

    task automatic test_stall_commit();
        logic [NC*DW-1:0] held;
        held = const_out;
        fft_idle = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin wr_valid = 1'b1; wr_addr = AW'(2); wr_data = BW'(7); end
            tick();
            wr_valid = 1'b0;
            n_chk++;
            if (wr_ready !== 1'b0 || commit_done !== 1'b0 || wr_err !== 1'b0 ||
                modulus !== MOD[DW-1:0] || const_out !== held) begin
                n_err++; $display("FAIL stall_%0d: ready=%b done=%b err=%b mod=%0d exp 0/0/0 %0d",
                    i, wr_ready, commit_done, wr_err, modulus, MOD);
            end
        end
        fft_idle = 1'b1;
        tick();
        n_chk++;
        if (commit_done !== 1'b1 || !exp_done) begin n_err++; $display("FAIL stall_release: done=%b exp 1", commit_done); end
        tick();
        n_chk++;
        if (const_out !== m_cq || inv_out !== act_inv_set() || wr_ready !== 1'b1) begin
            n_err++; $display("FAIL shadow_kept: c30=%0d exp %0d ready=%b",
                const_out[14*DW +: DW], m_cq[14*DW +: DW], wr_ready);
        end
    endtask

    task automatic test_mod_only_recommit();
        wr(0, BW'(1000003));
        n_chk++;
        if (wr_err !== 1'b0) begin n_err++; $display("FAIL new_mod_accept: wr_err=%b exp 0", wr_err); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_chk++;
        if (commit_err !== 1'b1 || !exp_cerr || wr_ready !== 1'b1) begin
            n_err++; $display("FAIL mod_only_commit: cerr=%b ready=%b exp 1/1", commit_err, wr_ready);
        end
        tick();
        n_chk++;
        if (modulus !== MOD[DW-1:0] || const_out !== m_cq || cfg_valid !== 1'b1) begin
            n_err++; $display("FAIL old_active_kept: mod=%0d exp %0d", modulus, MOD);
        end
    endtask

    task automatic test_reset_pend();
        load_set();
        fft_idle = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        n_chk++;
        if (wr_ready !== 1'b0) begin n_err++; $display("FAIL in_pend: ready=%b exp 0", wr_ready); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (modulus !== '0 || pre_computing !== '0 || const_out !== '0 || inv_out !== '0 ||
            {wr_err, commit_done, commit_err, cfg_valid} !== 4'b0 || wr_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_pend: mod=%0d cfg=%b ready=%b exp 0/0/1", modulus, cfg_valid, wr_ready);
        end
        rst_n = 1'b1;
        fft_idle = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (commit_done !== 1'b0 || cfg_valid !== 1'b0 || wr_ready !== 1'b1) begin
                n_err++; $display("FAIL after_abort_%0d: done=%b cfg=%b exp 0/0", i, commit_done, cfg_valid);
            end
        end
    endtask

    task automatic test_random();
        int ptr = 1;
        int r;
        wr(0, MOD);
        for (int cyc = 0; cyc < 800; cyc++) begin
            int a;
            logic [BW-1:0] d;
            r = $urandom_range(0, 99);
            if (r < 1) a = 0;
            else if (r < 70) begin a = ptr; ptr = (ptr == NE - 1) ? 1 : ptr + 1; end
            else if (r < 94) a = $urandom_range(1, NE - 1);
            else a = $urandom_range(NE, (1 << AW) - 1);
            if (a == 0) begin
                case ($urandom_range(0, 5))
                    0: d = BW'(1);
                    1: d = BW'($urandom_range(2, 24'hFFFFFF) & ~1);
                    default: d = BW'($urandom_range(3, 24'hFFFFFF) | 1);
                endcase
            end else begin
                case ($urandom_range(0, 7))
                    0: d = BW'({$urandom, $urandom});
                    1: d = m_sh[0];
                    default: d = (m_sh[0] != 0) ? BW'($urandom % m_sh[0][31:0]) : BW'($urandom);
                endcase
            end
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr = AW'(a);
            wr_data = d;
            commit = ($urandom_range(0, 7) == 0);
            fft_idle = ($urandom_range(0, 2) != 0);
            inverse = $urandom_range(0, 1);
            tick();
            n_chk++;
            if (wr_err !== exp_wr_err || commit_done !== exp_done || commit_err !== exp_cerr ||
                cfg_valid !== m_cfg || wr_ready !== !m_pend) begin
                n_err++; $display("FAIL rnd_ctrl_%0d: err/done/cerr/cfg/rdy=%b%b%b%b%b exp %b%b%b%b%b", cyc,
                    wr_err, commit_done, commit_err, cfg_valid, wr_ready,
                    exp_wr_err, exp_done, exp_cerr, m_cfg, !m_pend);
            end
            n_chk++;
            if (modulus !== m_act[0][DW-1:0] || pre_computing !== m_act[1] ||
                inv_out !== act_inv_set() || const_out !== m_cq) begin
                n_err++; $display("FAIL rnd_data_%0d: mod=%0d exp %0d pre=%0d exp %0d", cyc,
                    modulus, m_act[0][DW-1:0], pre_computing, m_act[1]);
            end
        end
        wr_valid = 1'b0;
        commit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_inverse();
        test_bad_writes();
        test_stall_commit();
        test_mod_only_recommit();
        test_reset_pend();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ntt_const_bank.md
# ntt_const_bank

Runtime-programmable constant bank for the NTT/FFT datapath. It holds the modulus, the Barrett pre-compute constant, the forward and inverse small-DFT twiddle constants (C70..C77, C50..C54, C40, C30, C31) and the modular inverses inv_2/3/4/5/7. Host software writes a shadow set, and the bank commits it atomically into the active set only while the FFT core is idle. It replaces the hard-wired constant table, so one netlist serves any modulus up to DATA_WIDTH bits.

## Interface
- DATA_WIDTH, 50, width of modulus and every constant
- BR_WIDTH, 53, width of the Barrett pre-compute constant; must be ≥ DATA_WIDTH
- NUM_C, 16, twiddle constants per direction; slot order is C70..C77, C50..C54, C40, C30, C31
- NUM_INV, 5, inverse constants; slot order is inv_2, inv_3, inv_4, inv_5, inv_7
- ADDR_W, 6, write-address width; 2^ADDR_W must be ≥ 2+2*NUM_C+NUM_INV
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_W  shadow entry address
- wr_data  in  BR_WIDTH  write data
- wr_err  out  1  one-cycle pulse: last accepted write was rejected
- commit  in  1  request to copy the shadow set to the active set
- fft_idle  in  1  FFT core has no transform in flight
- commit_done  out  1  one-cycle pulse: copy performed
- commit_err  out  1  one-cycle pulse: commit refused
- cfg_valid  out  1  active set holds a committed configuration
- inverse  in  1  selects the inverse twiddle set
- modulus  out  DATA_WIDTH  active modulus
- pre_computing  out  BR_WIDTH  active Barrett constant
- const_out  out  NUM_C*DATA_WIDTH  selected twiddles; slot k is bits [k*DATA_WIDTH +: DATA_WIDTH]
- inv_out  out  NUM_INV*DATA_WIDTH  active inverses, packed the same way

## Operation
- Address map:
  - 0: modulus
  - 1: Barrett constant
  - 2..1+NUM_C: forward C
  - 2+NUM_C..1+2*NUM_C: inverse C
  - next NUM_INV addresses: inverses
  - anything above: illegal
- Write checks. A failing write leaves the shadow set unchanged and pulses wr_err.
  - Modulus: wr_data[BR_WIDTH-1:DATA_WIDTH] must be 0, and the value must be odd and ≥3.
  - Barrett: any value is accepted.
  - Constants: upper bits must be 0, and the value must be < the shadow modulus.
  - Illegal address: always rejected.
- Written mask: each successful write sets that entry's bit. A successful modulus write clears the bits of all constant and inverse entries but keeps its own bit and the Barrett bit.
- FSM, states IDLE and PEND:
  - IDLE: wr_ready=1. When commit is seen, the mask is checked, including any write accepted that same cycle.
    - Mask incomplete: commit_err pulses and the FSM stays in IDLE.
    - Mask complete: go to PEND.
  - PEND: wr_ready=0 and commit is ignored. On an edge with fft_idle=1, active ← shadow, cfg_valid ← 1, commit_done pulses, and the FSM returns to IDLE.
- The shadow set and mask persist after a commit, so partial rewrites followed by a recommit are legal.
- const_out is registered: each cycle it loads the active inverse set if inverse=1, otherwise the active forward set.
- modulus, pre_computing and inv_out drive directly from the active registers.

## Timing
- Reset (async assert, any state): FSM goes to IDLE, and all shadow, active and mask registers clear to 0. Every output is 0 except wr_ready, which is 1 (wr_ready follows the FSM state, so it returns to 1 as soon as the FSM is in IDLE). Reset during PEND aborts the commit with no commit_done.
- Write: the shadow entry updates at the accepting edge. wr_err is high during the following cycle.
- Commit latency with fft_idle held at 1:
  - Edge N samples commit.
  - Edge N+1 performs the copy.
  - commit_done and cfg_valid are high after N+1.
  - const_out reflects the new set after N+2.
- inverse toggle: const_out changes one cycle later.
- fft_idle low in PEND: the FSM waits indefinitely and the active set is untouched.

## Test plan
- Reset → every output is 0, wr_ready=1, cfg_valid=0. Commit with the mask empty → commit_err pulse and no state change.
- Full load with fft_idle=1, then commit → commit_done one pulse, cfg_valid=1, modulus=55822321, pre_computing=161354796. Values loaded:
  - modulus 55822321, Barrett 161354796
  - C52 forward 21016252, C52 inverse 34806069, C31 forward 49886006
  - inv_2 27911161
- After that commit:
  - inverse=0 → C52 slot = 21016252
  - inverse=1 → C52 slot = 34806069 one cycle later
  - inv_out slot 0 = 27911161
- Write C30 slot with 55822321 (equal to the modulus) → wr_err. Write to address 40 → wr_err. Write an even modulus 55822320 → wr_err. Mask and shadow are unchanged in all three cases.
- Commit with fft_idle=0 for 10 cycles → wr_ready=0 and outputs unchanged. Raise fft_idle → copy on the next edge and commit_done pulses.
- After a committed load, write only the modulus, then commit → commit_err, and the active set still outputs the old values.
- Assert rst_n=0 while in PEND → immediate clear of all outputs, and no commit_done afterwards.
